branch_pred_unit: RTL and testbench

- Parametrised successor to the combinational branch condition generator for the pipelined OTTER core.
- Resolves B-type, JAL and JALR in EX and drives a widened PC_SEL with misprediction recovery.
- Owns a BHT of 2-bit saturating counters: read combinationally by IF for a taken/not-taken prediction, updated by EX on every resolved conditional branch.
- Keeps saturating branch and mispredict counters for performance measurement.

---
 rtl/branch_pred_unit_if.sv | 33 +++
 rtl/branch_pred_unit.sv | 157 +++++++++++++++
 tb/tb_branch_pred_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/branch_pred_unit_if.sv
// Bundle between the OTTER pipeline (IF/EX stages) and the branch prediction unit.
// Latency: not applicable (wires only).
// Backpressure: none; EX_VALID marks a live EX-stage instruction.
interface branch_pred_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  IF_PC;
    logic             IF_PRED_TAKEN;
    logic             EX_VALID;
    logic [31:0]      EX_IR;
    logic [XLEN-1:0]  EX_PC;
    logic             EX_PRED_TAKEN;
    logic [XLEN-1:0]  RS1;
    logic [XLEN-1:0]  RS2;
    logic [2:0]       PC_SEL;
    logic             FLUSH;
    logic             ILLEGAL_BR;
    logic [CNT_W-1:0] BR_CNT;
    logic [CNT_W-1:0] MISS_CNT;

    // Pipeline side: drives fetch PC and the EX-stage instruction.
    modport master (
        output IF_PC, EX_VALID, EX_IR, EX_PC, EX_PRED_TAKEN, RS1, RS2,
        input  IF_PRED_TAKEN, PC_SEL, FLUSH, ILLEGAL_BR, BR_CNT, MISS_CNT
    );

    // Predictor side.
    modport slave (
        input  IF_PC, EX_VALID, EX_IR, EX_PC, EX_PRED_TAKEN, RS1, RS2,
        output IF_PRED_TAKEN, PC_SEL, FLUSH, ILLEGAL_BR, BR_CNT, MISS_CNT
    );
endinterface

// File: rtl/branch_pred_unit.sv
// Branch resolution (B/JAL/JALR) with 2-bit BHT prediction and mispredict recovery.
// Latency: prediction and resolution are combinational; BHT/counter updates land on the next CLK edge.
// Backpressure: none; a stalled/bubbled EX stage drops EX_VALID and nothing resolves or updates.
module branch_pred_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    branch_pred_unit_if.slave bp
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] SEL_SEQ     = 3'b000;
    localparam logic [2:0] SEL_JALR    = 3'b001;
    localparam logic [2:0] SEL_BRANCH  = 3'b010;
    localparam logic [2:0] SEL_JAL     = 3'b011;
    localparam logic [2:0] SEL_RECOVER = 3'b100;

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_entry_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic             eq, lt, ltu;
    logic             cond_taken;
    logic             legal_f3;
    logic             br_upd;
    logic             mispred;
    logic [2:0]       pc_sel;
    logic             flush;
    logic             illegal;
    logic             unused_bits;

    assign if_idx = bp.IF_PC[IDX_W+1:2];
    assign ex_idx = bp.EX_PC[IDX_W+1:2];
    assign opcode = bp.EX_IR[6:0];
    assign func3  = bp.EX_IR[14:12];

    assign eq  = (bp.RS1 == bp.RS2);
    assign lt  = ($signed(bp.RS1) < $signed(bp.RS2));
    assign ltu = (bp.RS1 < bp.RS2);

    // PC bits outside the index and IR fields not needed for resolution.
    assign unused_bits = ^{bp.IF_PC[XLEN-1:IDX_W+2], bp.IF_PC[1:0],
                           bp.EX_PC[XLEN-1:IDX_W+2], bp.EX_PC[1:0],
                           bp.EX_IR[31:15], bp.EX_IR[11:7]};

    // Evaluate the branch condition selected by func3; 010/011 are not branches.
    always_comb begin
        cond_taken = 1'b0;
        legal_f3   = 1'b1;
        case (func3)
            3'b000:  cond_taken = eq;
            3'b001:  cond_taken = !eq;
            3'b100:  cond_taken = lt;
            3'b101:  cond_taken = !lt;
            3'b110:  cond_taken = ltu;
            3'b111:  cond_taken = !ltu;
            default: legal_f3   = 1'b0;
        endcase
    end

    // Resolve the EX instruction into a PC select, flush and update strobe.
    always_comb begin
        pc_sel  = SEL_SEQ;
        flush   = 1'b0;
        illegal = 1'b0;
        br_upd  = 1'b0;
        mispred = 1'b0;
        if (bp.EX_VALID) begin
            case (opcode)
                OP_JAL: begin
                    pc_sel = SEL_JAL;
                    flush  = 1'b1;
                end
                OP_JALR: begin
                    pc_sel = SEL_JALR;
                    flush  = 1'b1;
                end
                OP_BRANCH: begin
                    if (legal_f3) begin
                        br_upd  = 1'b1;
                        mispred = (cond_taken != bp.EX_PRED_TAKEN);
                        if (cond_taken && !bp.EX_PRED_TAKEN) begin
                            pc_sel = SEL_BRANCH;
                            flush  = 1'b1;
                        end else if (!cond_taken && bp.EX_PRED_TAKEN) begin
                            pc_sel = SEL_RECOVER;
                            flush  = 1'b1;
                        end
                    end else begin
                        illegal = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next value of the BHT entry being trained, saturating at 00 and 11.
    always_comb begin
        bht_entry_d = bht_q[ex_idx];
        if (cond_taken) begin
            if (bht_q[ex_idx] != 2'b11) bht_entry_d = bht_q[ex_idx] + 2'b01;
        end else begin
            if (bht_q[ex_idx] != 2'b00) bht_entry_d = bht_q[ex_idx] - 2'b01;
        end
    end

    // Statistics counters hold at all-ones instead of wrapping.
    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (br_upd) begin
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
            if (mispred && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    // Train the BHT on every resolved conditional branch; reset to weakly not-taken.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else if (br_upd) begin
            bht_q[ex_idx] <= bht_entry_d;
        end
    end

    // Register the performance counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // IF reads the stored entry directly: a same-cycle update is seen next cycle.
    assign bp.IF_PRED_TAKEN = bht_q[if_idx][1];
    assign bp.PC_SEL        = pc_sel;
    assign bp.FLUSH         = flush;
    assign bp.ILLEGAL_BR    = illegal;
    assign bp.BR_CNT        = br_cnt_q;
    assign bp.MISS_CNT      = miss_cnt_q;
endmodule

// File: tb/tb_branch_pred_unit.sv
// Scoreboard bench for branch_pred_unit: stimulus pushes expected outputs, a negedge monitor compares.
// Latency: each vector is checked at the negedge following its drive.
// Backpressure: none.
module tb_branch_pred_unit;
    logic clk;
    logic rst_n;

    branch_pred_unit_if #(.XLEN(32), .CNT_W(4)) bp_if ();

    branch_pred_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bp    (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] pc_sel;
        logic       flush;
        logic       ill;
        logic       pred;
        int         br;
        int         miss;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] NEG1 = 32'hFFFF_FFFF;
    localparam logic [31:0] IR_JAL  = 32'h0000_006F;
    localparam logic [31:0] IR_JALR = 32'h0000_0067;
    localparam logic [31:0] IR_ADDI = 32'h0000_0013;

    function automatic logic [31:0] btype(input logic [2:0] f3);
        return {17'd0, f3, 5'd0, 7'b1100011};
    endfunction

    // Monitor: compare the full output tuple against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bp_if.PC_SEL !== mon_e.pc_sel || bp_if.FLUSH !== mon_e.flush ||
                bp_if.ILLEGAL_BR !== mon_e.ill || bp_if.IF_PRED_TAKEN !== mon_e.pred ||
                int'(bp_if.BR_CNT) != mon_e.br || int'(bp_if.MISS_CNT) != mon_e.miss) begin
                errors++;
                $display("FAIL %s: got sel=%b fl=%b ill=%b pred=%b br=%0d miss=%0d exp sel=%b fl=%b ill=%b pred=%b br=%0d miss=%0d",
                         mon_e.name, bp_if.PC_SEL, bp_if.FLUSH, bp_if.ILLEGAL_BR, bp_if.IF_PRED_TAKEN,
                         bp_if.BR_CNT, bp_if.MISS_CNT, mon_e.pc_sel, mon_e.flush, mon_e.ill,
                         mon_e.pred, mon_e.br, mon_e.miss);
            end
        end
    end

    task automatic push_exp(input string name, input logic [2:0] ps, input logic fl, input logic il,
                            input logic pr, input int br, input int miss);
        exp_t e;
        e.name = name; e.pc_sel = ps; e.flush = fl; e.ill = il; e.pred = pr; e.br = br; e.miss = miss;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] ex_pc, input logic pin,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] if_pc);
        bp_if.EX_VALID      = v;
        bp_if.EX_IR         = ir;
        bp_if.EX_PC         = ex_pc;
        bp_if.EX_PRED_TAKEN = pin;
        bp_if.RS1           = a;
        bp_if.RS2           = b;
        bp_if.IF_PC         = if_pc;
    endtask

    task automatic step(input string name, input logic v, input logic [31:0] ir, input logic [31:0] ex_pc,
                        input logic pin, input logic [31:0] a, input logic [31:0] b, input logic [31:0] if_pc,
                        input logic [2:0] ps, input logic fl, input logic il, input logic pr,
                        input int br, input int miss);
        @(posedge clk);
        #1;
        drive(v, ir, ex_pc, pin, a, b, if_pc);
        push_exp(name, ps, fl, il, pr, br, miss);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //    name          v     ir            ex_pc     pin   rs1    rs2    if_pc     sel     fl    il    pr    br  miss
        step("reset",       1'b0, 32'd0,        32'h40,   1'b0, 32'd0, 32'd0, 32'h40,   3'b000, 1'b0, 1'b0, 1'b0, 0,  0);
        step("beq_miss",    1'b1, btype(3'b000),32'h40,   1'b0, 32'd5, 32'd5, 32'h40,   3'b010, 1'b1, 1'b0, 1'b0, 0,  0);
        step("bht16_upd",   1'b0, 32'd0,        32'h40,   1'b0, 32'd0, 32'd0, 32'h40,   3'b000, 1'b0, 1'b0, 1'b1, 1,  1);
        step("blt_taken",   1'b1, btype(3'b100),32'h80,   1'b1, NEG1,  32'd1, 32'h80,   3'b000, 1'b0, 1'b0, 1'b0, 1,  1);
        step("bltu_recov",  1'b1, btype(3'b110),32'h80,   1'b1, NEG1,  32'd1, 32'h80,   3'b100, 1'b1, 1'b0, 1'b1, 2,  1);
        step("bne_t1",      1'b1, btype(3'b001),32'hC0,   1'b0, 32'd1, 32'd2, 32'hC0,   3'b010, 1'b1, 1'b0, 1'b0, 3,  2);
        step("bne_t2",      1'b1, btype(3'b001),32'hC0,   1'b1, 32'd1, 32'd2, 32'hC0,   3'b000, 1'b0, 1'b0, 1'b1, 4,  3);
        step("bne_t3",      1'b1, btype(3'b001),32'hC0,   1'b1, 32'd1, 32'd2, 32'hC0,   3'b000, 1'b0, 1'b0, 1'b1, 5,  3);
        step("bne_t4",      1'b1, btype(3'b001),32'hC0,   1'b1, 32'd1, 32'd2, 32'hC0,   3'b000, 1'b0, 1'b0, 1'b1, 6,  3);
        step("sat_hi",      1'b0, 32'd0,        32'hC0,   1'b0, 32'd0, 32'd0, 32'hC0,   3'b000, 1'b0, 1'b0, 1'b1, 7,  3);
        step("bne_nt1",     1'b1, btype(3'b001),32'hC0,   1'b1, 32'd3, 32'd3, 32'hC0,   3'b100, 1'b1, 1'b0, 1'b1, 7,  3);
        step("bne_nt2",     1'b1, btype(3'b001),32'hC0,   1'b1, 32'd3, 32'd3, 32'hC0,   3'b100, 1'b1, 1'b0, 1'b1, 8,  4);
        step("nt_result",   1'b0, 32'd0,        32'hC0,   1'b0, 32'd0, 32'd0, 32'hC0,   3'b000, 1'b0, 1'b0, 1'b0, 9,  5);
        step("jal",         1'b1, IR_JAL,       32'hC0,   1'b0, 32'd0, 32'd0, 32'hC0,   3'b011, 1'b1, 1'b0, 1'b0, 9,  5);
        step("jalr",        1'b1, IR_JALR,      32'hC0,   1'b0, 32'd0, 32'd0, 32'hC0,   3'b001, 1'b1, 1'b0, 1'b0, 9,  5);
        step("ill_f3_010",  1'b1, btype(3'b010),32'h40,   1'b0, 32'd5, 32'd5, 32'h40,   3'b000, 1'b0, 1'b1, 1'b1, 9,  5);
        step("ill_f3_011",  1'b1, btype(3'b011),32'h40,   1'b0, 32'd5, 32'd6, 32'h40,   3'b000, 1'b0, 1'b1, 1'b1, 9,  5);
        step("after_ill",   1'b0, 32'd0,        32'h40,   1'b0, 32'd0, 32'd0, 32'h40,   3'b000, 1'b0, 1'b0, 1'b1, 9,  5);
        step("bge_nt1",     1'b1, btype(3'b101),32'h100,  1'b0, NEG1,  32'd1, 32'h100,  3'b000, 1'b0, 1'b0, 1'b0, 9,  5);
        step("bge_nt2",     1'b1, btype(3'b101),32'h100,  1'b0, NEG1,  32'd1, 32'h100,  3'b000, 1'b0, 1'b0, 1'b0, 10, 5);
        step("bgeu_t",      1'b1, btype(3'b111),32'h100,  1'b0, NEG1,  32'd1, 32'h100,  3'b010, 1'b1, 1'b0, 1'b0, 11, 5);
        step("addi_sat_lo", 1'b1, IR_ADDI,      32'h100,  1'b0, 32'd0, 32'd0, 32'h100,  3'b000, 1'b0, 1'b0, 1'b0, 12, 6);
        step("jal_bubble",  1'b0, IR_JAL,       32'h100,  1'b0, 32'd0, 32'd0, 32'h100,  3'b000, 1'b0, 1'b0, 1'b0, 12, 6);
        step("beq17_a",     1'b1, btype(3'b000),32'h44,   1'b0, 32'd7, 32'd7, 32'h44,   3'b010, 1'b1, 1'b0, 1'b0, 12, 6);
        step("beq17_b",     1'b1, btype(3'b000),32'h44,   1'b0, 32'd7, 32'd7, 32'h44,   3'b010, 1'b1, 1'b0, 1'b1, 13, 7);
        step("beq17_c",     1'b1, btype(3'b000),32'h44,   1'b0, 32'd7, 32'd7, 32'h44,   3'b010, 1'b1, 1'b0, 1'b1, 14, 8);
        step("beq17_d",     1'b1, btype(3'b000),32'h44,   1'b0, 32'd7, 32'd7, 32'h44,   3'b010, 1'b1, 1'b0, 1'b1, 15, 9);
        step("beq17_e",     1'b1, btype(3'b000),32'h44,   1'b0, 32'd7, 32'd7, 32'h44,   3'b010, 1'b1, 1'b0, 1'b1, 15, 10);
        step("cnt_sat",     1'b0, 32'd0,        32'h44,   1'b0, 32'd0, 32'd0, 32'h44,   3'b000, 1'b0, 1'b0, 1'b1, 15, 11);

        // Asynchronous reset between clock edges: BHT[17] was 11, counters non-zero.
        @(posedge clk);
        #1;
        drive(1'b0, 32'd0, 32'h44, 1'b0, 32'd0, 32'd0, 32'h44);
        #1;
        rst_n = 1'b0;
        push_exp("async_rst", 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

        step("rst_comb",    1'b1, btype(3'b000),32'h44,   1'b0, 32'd9, 32'd9, 32'h44,   3'b010, 1'b1, 1'b0, 1'b0, 0,  0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst",    1'b0, 32'd0,        32'h44,   1'b0, 32'd0, 32'd0, 32'h44,   3'b000, 1'b0, 1'b0, 1'b1, 1,  1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
